// File: rtl/novaedge_pkg.sv
// Shared NovaEdge32 decode definitions: opcodes, immediate format codes,
// extractor control encodings and the decoded payload record.
package novaedge_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  // ctrl[0] picks I; otherwise ctrl[2:1] picks among U/S/J/B.
  localparam logic [2:0] CTRL_I = 3'b001;
  localparam logic [2:0] CTRL_U = 3'b000;
  localparam logic [2:0] CTRL_S = 3'b010;
  localparam logic [2:0] CTRL_J = 3'b100;
  localparam logic [2:0] CTRL_B = 3'b110;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_t   imm_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for imm_decode_stage.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import novaedge_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  imm_type_t       out_imm_type;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_imm_type,
           out_rd, out_rs1, out_rs2, out_funct3, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_imm_type,
           out_rd, out_rs1, out_rs2, out_funct3, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage_imm_unit.sv
// Combinational immediate extractor; RESET_IMM is produced whenever en is low.
module imm_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_IMM = '0
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      ctrl,
  input  logic            en,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = RESET_IMM;
    if (en) begin
      if (ctrl[0]) begin
        imm = {{20{instr[31]}}, instr[31:20]};
      end else begin
        case (ctrl[2:1])
          2'b00:   imm = {instr[31:12], 12'b0};
          2'b01:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          2'b10:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
          default: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
        endcase
      end
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode front end: opcode classification, immediate extraction, output register.
// Define IMM_DECODE_SKID_EN for a one-entry skid buffer with registered in_ready.
module imm_decode_stage
  import novaedge_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_IMM = '0
) (
  input logic               clk,
  input logic               rst_n,
  imm_decode_stage_if.slave bus
);

  localparam decoded_t RST_PAYLOAD = '{
    pc: '0, imm: RESET_IMM, imm_type: IMM_NONE,
    rd: '0, rs1: '0, rs2: '0, funct3: '0, illegal: 1'b0
  };

  imm_type_t   dec_type;
  logic [2:0]  dec_ctrl;
  logic        dec_en;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  decoded_t    dec;
  logic        accept;
  logic        out_valid;
  decoded_t    out_q;

  always_comb begin
    dec_type    = IMM_NONE;
    dec_ctrl    = CTRL_U;
    dec_en      = 1'b0;
    dec_illegal = 1'b0;
    case (bus.in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec_type = IMM_I; dec_ctrl = CTRL_I; dec_en = 1'b1;
      end
      OP_STORE:        begin dec_type = IMM_S; dec_ctrl = CTRL_S; dec_en = 1'b1; end
      OP_BRANCH:       begin dec_type = IMM_B; dec_ctrl = CTRL_B; dec_en = 1'b1; end
      OP_LUI, OP_AUIPC: begin dec_type = IMM_U; dec_ctrl = CTRL_U; dec_en = 1'b1; end
      OP_JAL:          begin dec_type = IMM_J; dec_ctrl = CTRL_J; dec_en = 1'b1; end
      OP_OP:           dec_type = IMM_NONE;
      default:         dec_illegal = 1'b1;
    endcase
  end

  imm_unit #(
    .XLEN      (XLEN),
    .RESET_IMM (RESET_IMM)
  ) u_imm (
    .instr (bus.in_instr[31:7]),
    .ctrl  (dec_ctrl),
    .en    (dec_en),
    .imm   (dec_imm)
  );

  assign dec = '{
    pc: bus.in_pc, imm: dec_imm, imm_type: dec_type,
    rd: bus.in_instr[11:7], rs1: bus.in_instr[19:15], rs2: bus.in_instr[24:20],
    funct3: bus.in_instr[14:12], illegal: dec_illegal
  };

`ifdef IMM_DECODE_SKID_EN
  logic     skid_valid;
  decoded_t skid_q;

  // in_ready comes straight off the skid flop; flush only forces it high
  // because anything presented that cycle is dropped anyway.
  assign bus.in_ready = !skid_valid || bus.flush;
  assign accept       = bus.in_valid && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= RST_PAYLOAD;
      skid_valid <= 1'b0;
      skid_q     <= RST_PAYLOAD;
    end else if (bus.flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || bus.out_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign bus.in_ready = !out_valid || bus.out_ready || bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= RST_PAYLOAD;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_imm_type = out_q.imm_type;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_funct3   = out_q.funct3;
  assign bus.out_illegal  = out_q.illegal;

endmodule
